// File: rtl/ex_stage_if.sv
// Signal bundle between the ID/EX register, the execute stage and the MEM stage.
// The slave modport is the execute stage's view of the bundle.
interface ex_stage_if #(
   parameter int ADDR_W = 32,
   parameter int REG_W  = 32,
   parameter int RA_W   = 5,
   parameter int OP_W   = 6
);
   logic              in_valid;
   logic [ADDR_W-1:0] in_pc;
   logic [REG_W-1:0]  in_reg1;
   logic [REG_W-1:0]  in_reg2;
   logic [REG_W-1:0]  in_Imm;
   logic [RA_W-1:0]   in_rd;
   logic [OP_W-1:0]   in_op;
   logic              mem_stall;
   logic              ex_busy;
   logic              out_valid;
   logic [OP_W-1:0]   out_op;
   logic [RA_W-1:0]   out_rd;
   logic              out_wen;
   logic [REG_W-1:0]  out_wdata;
   logic [ADDR_W-1:0] out_addr;
   logic [REG_W-1:0]  out_sdata;
   logic              br_taken;
   logic [ADDR_W-1:0] br_target;

   modport master (
      output in_valid, in_pc, in_reg1, in_reg2, in_Imm, in_rd, in_op, mem_stall,
      input  ex_busy, out_valid, out_op, out_rd, out_wen, out_wdata, out_addr, out_sdata,
             br_taken, br_target
   );

   modport slave (
      input  in_valid, in_pc, in_reg1, in_reg2, in_Imm, in_rd, in_op, mem_stall,
      output ex_busy, out_valid, out_op, out_rd, out_wen, out_wdata, out_addr, out_sdata,
             br_taken, br_target
   );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ALU, effective address and branch resolution, registered towards MEM.
// Shifts optionally run one bit per cycle; ex_busy back-pressures ID/EX while shifting or held.
module ex_stage #(
   parameter bit SERIAL_SHIFT = 1'b1
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      rdy,
   ex_stage_if.slave bus
);
   localparam logic [5:0] OP_NOP = 6'd0,  OP_ADD = 6'd1,  OP_SUB = 6'd2,  OP_SLL = 6'd3;
   localparam logic [5:0] OP_SLT = 6'd4,  OP_SLTU = 6'd5, OP_XOR = 6'd6,  OP_SRL = 6'd7;
   localparam logic [5:0] OP_SRA = 6'd8,  OP_OR = 6'd9,   OP_AND = 6'd10, OP_ADDI = 6'd11;
   localparam logic [5:0] OP_SLTI = 6'd12, OP_SLTIU = 6'd13, OP_XORI = 6'd14, OP_ORI = 6'd15;
   localparam logic [5:0] OP_ANDI = 6'd16, OP_SLLI = 6'd17, OP_SRLI = 6'd18, OP_SRAI = 6'd19;
   localparam logic [5:0] OP_LUI = 6'd20, OP_AUIPC = 6'd21, OP_JAL = 6'd22, OP_JALR = 6'd23;
   localparam logic [5:0] OP_BEQ = 6'd24, OP_BNE = 6'd25, OP_BLT = 6'd26, OP_BGE = 6'd27;
   localparam logic [5:0] OP_BLTU = 6'd28, OP_BGEU = 6'd29;
   localparam logic [5:0] OP_SB = 6'd35, OP_SH = 6'd36, OP_SW = 6'd37;

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] sh_val_q, sh_val_d;
   logic [5:0]  sh_op_q, sh_op_d;
   logic [4:0]  sh_rd_q, sh_rd_d;
   logic        out_valid_q, out_valid_d;
   logic [5:0]  out_op_q, out_op_d;
   logic [4:0]  out_rd_q, out_rd_d;
   logic        out_wen_q, out_wen_d;
   logic [31:0] out_wdata_q, out_wdata_d;
   logic [31:0] out_addr_q, out_addr_d;
   logic [31:0] out_sdata_q, out_sdata_d;
   logic        br_taken_q, br_taken_d;
   logic [31:0] br_target_q, br_target_d;

   function automatic logic [31:0] shift1(input logic [5:0] op, input logic [31:0] v);
      case (op)
         OP_SLL, OP_SLLI: shift1 = {v[30:0], 1'b0};
         OP_SRA, OP_SRAI: shift1 = {v[31], v[31:1]};
         default:         shift1 = {1'b0, v[31:1]};
      endcase
   endfunction

   logic [31:0]        op2, shift_res, alu_res, tgt, ea;
   logic signed [31:0] a_s, b_s;
   logic [4:0]         shamt;
   logic               taken, is_shift, is_branch, is_store, stall_out, start_shift;

   assign op2       = (bus.in_op >= OP_ADDI && bus.in_op <= OP_SRAI) ? bus.in_Imm : bus.in_reg2;
   assign a_s       = signed'(bus.in_reg1);
   assign b_s       = signed'(op2);
   assign shamt     = op2[4:0];
   assign ea        = bus.in_reg1 + bus.in_Imm;
   assign is_shift  = bus.in_op inside {OP_SLL, OP_SRL, OP_SRA, OP_SLLI, OP_SRLI, OP_SRAI};
   assign is_branch = bus.in_op >= OP_BEQ && bus.in_op <= OP_BGEU;
   assign is_store  = bus.in_op inside {OP_SB, OP_SH, OP_SW};
   assign stall_out = bus.mem_stall & out_valid_q;
   // Shifts of 0 or 1 finish in one cycle anyway, so only longer ones go iterative.
   assign start_shift = SERIAL_SHIFT && (state_q != SHIFT) && !stall_out && bus.in_valid
                        && is_shift && (shamt > 5'd1);

   always_comb begin
      if (SERIAL_SHIFT) begin
         shift_res = (shamt == 5'd0) ? bus.in_reg1 : shift1(bus.in_op, bus.in_reg1);
      end else begin
         case (bus.in_op)
            OP_SLL, OP_SLLI: shift_res = bus.in_reg1 << shamt;
            OP_SRA, OP_SRAI: shift_res = unsigned'(a_s >>> shamt);
            default:         shift_res = bus.in_reg1 >> shamt;
         endcase
      end
   end

   always_comb begin
      alu_res = '0;
      tgt     = bus.in_pc + bus.in_Imm;
      taken   = 1'b0;
      case (bus.in_op)
         OP_ADD, OP_ADDI:   alu_res = bus.in_reg1 + op2;
         OP_SUB:            alu_res = bus.in_reg1 - op2;
         OP_SLT, OP_SLTI:   alu_res = {31'd0, a_s < b_s};
         OP_SLTU, OP_SLTIU: alu_res = {31'd0, bus.in_reg1 < op2};
         OP_XOR, OP_XORI:   alu_res = bus.in_reg1 ^ op2;
         OP_OR, OP_ORI:     alu_res = bus.in_reg1 | op2;
         OP_AND, OP_ANDI:   alu_res = bus.in_reg1 & op2;
         OP_SLL, OP_SLLI, OP_SRL, OP_SRLI, OP_SRA, OP_SRAI: alu_res = shift_res;
         OP_LUI:            alu_res = bus.in_Imm;
         OP_AUIPC:          alu_res = bus.in_pc + bus.in_Imm;
         OP_JAL: begin
            alu_res = bus.in_pc + 32'd4;
            taken   = 1'b1;
         end
         OP_JALR: begin
            alu_res = bus.in_pc + 32'd4;
            tgt     = ea & ~32'd1;
            taken   = 1'b1;
         end
         OP_BEQ:  taken = bus.in_reg1 == op2;
         OP_BNE:  taken = bus.in_reg1 != op2;
         OP_BLT:  taken = a_s < b_s;
         OP_BGE:  taken = a_s >= b_s;
         OP_BLTU: taken = bus.in_reg1 < op2;
         OP_BGEU: taken = bus.in_reg1 >= op2;
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sh_val_d    = sh_val_q;
      sh_op_d     = sh_op_q;
      sh_rd_d     = sh_rd_q;
      out_valid_d = out_valid_q;
      out_op_d    = out_op_q;
      out_rd_d    = out_rd_q;
      out_wen_d   = out_wen_q;
      out_wdata_d = out_wdata_q;
      out_addr_d  = out_addr_q;
      out_sdata_d = out_sdata_q;
      br_taken_d  = 1'b0;
      br_target_d = br_target_q;
      if (state_q == SHIFT) begin
         // cnt_q counts shifts still to do; the entry edge already did the first one.
         sh_val_d = shift1(sh_op_q, sh_val_q);
         cnt_d    = cnt_q - 5'd1;
         if (cnt_q == 5'd1) begin
            state_d     = IDLE;
            out_valid_d = 1'b1;
            out_op_d    = sh_op_q;
            out_rd_d    = sh_rd_q;
            out_wen_d   = sh_rd_q != 5'd0;
            out_wdata_d = shift1(sh_op_q, sh_val_q);
         end
      end else if (stall_out) begin
         state_d = HOLD;
      end else begin
         state_d = IDLE;
         if (!bus.in_valid) begin
            out_valid_d = 1'b0;
            out_op_d    = OP_NOP;
            out_wen_d   = 1'b0;
         end else if (start_shift) begin
            state_d     = SHIFT;
            cnt_d       = shamt - 5'd1;
            sh_val_d    = shift1(bus.in_op, bus.in_reg1);
            sh_op_d     = bus.in_op;
            sh_rd_d     = bus.in_rd;
            out_valid_d = 1'b0;
            out_op_d    = OP_NOP;
            out_wen_d   = 1'b0;
            out_addr_d  = ea;
            out_sdata_d = bus.in_reg2;
         end else begin
            out_valid_d = 1'b1;
            out_op_d    = bus.in_op;
            out_rd_d    = bus.in_rd;
            out_wen_d   = (bus.in_rd != 5'd0) && !is_branch && !is_store && (bus.in_op != OP_NOP);
            out_wdata_d = alu_res;
            out_addr_d  = ea;
            out_sdata_d = bus.in_reg2;
            br_taken_d  = taken;
            br_target_d = tgt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sh_val_q    <= '0;
         sh_op_q     <= OP_NOP;
         sh_rd_q     <= '0;
         out_valid_q <= 1'b0;
         out_op_q    <= OP_NOP;
         out_rd_q    <= '0;
         out_wen_q   <= 1'b0;
         out_wdata_q <= '0;
         out_addr_q  <= '0;
         out_sdata_q <= '0;
         br_taken_q  <= 1'b0;
         br_target_q <= '0;
      end else if (rdy) begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sh_val_q    <= sh_val_d;
         sh_op_q     <= sh_op_d;
         sh_rd_q     <= sh_rd_d;
         out_valid_q <= out_valid_d;
         out_op_q    <= out_op_d;
         out_rd_q    <= out_rd_d;
         out_wen_q   <= out_wen_d;
         out_wdata_q <= out_wdata_d;
         out_addr_q  <= out_addr_d;
         out_sdata_q <= out_sdata_d;
         br_taken_q  <= br_taken_d;
         br_target_q <= br_target_d;
      end
   end

   assign bus.ex_busy   = (state_q == SHIFT) || (state_q == HOLD) || stall_out || start_shift;
   assign bus.out_valid = out_valid_q;
   assign bus.out_op    = out_op_q;
   assign bus.out_rd    = out_rd_q;
   assign bus.out_wen   = out_wen_q;
   assign bus.out_wdata = out_wdata_q;
   assign bus.out_addr  = out_addr_q;
   assign bus.out_sdata = out_sdata_q;
   assign bus.br_taken  = br_taken_q & rdy;
   assign bus.br_target = br_target_q;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: stimulus pushes expected results, a monitor pops and compares them.
module tb_ex_stage;
   localparam logic [5:0] OP_NOP = 6'd0,  OP_ADD = 6'd1,  OP_SUB = 6'd2,  OP_SLL = 6'd3;
   localparam logic [5:0] OP_SLT = 6'd4,  OP_SRL = 6'd7,  OP_SRA = 6'd8,  OP_ADDI = 6'd11;
   localparam logic [5:0] OP_SLTIU = 6'd13, OP_XORI = 6'd14, OP_SLLI = 6'd17, OP_SRAI = 6'd19;
   localparam logic [5:0] OP_LUI = 6'd20, OP_AUIPC = 6'd21, OP_JAL = 6'd22, OP_JALR = 6'd23;
   localparam logic [5:0] OP_BEQ = 6'd24, OP_BGE = 6'd27, OP_BLTU = 6'd28;
   localparam logic [5:0] OP_LW = 6'd32, OP_SW = 6'd37;

   typedef struct {
      logic [5:0]  op;
      logic [4:0]  rd;
      logic [31:0] wdata;
      bit          cwd;
      bit          wen;
      bit          taken;
      logic [31:0] tgt;
      bit          cmem;
      logic [31:0] addr;
      logic [31:0] sdata;
      int          due;
   } exp_t;

   logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1;
   logic        in_valid = 1'b0, mem_stall = 1'b0;
   logic [31:0] in_pc = '0, in_reg1 = '0, in_reg2 = '0, in_Imm = '0;
   logic [4:0]  in_rd = '0;
   logic [5:0]  in_op = '0;
   int          cyc = 0, checks = 0, failures = 0;
   exp_t        q[$];
   exp_t        mon_e;
   bit          seen = 1'b0;

   ex_stage_if bus0 ();
   ex_stage_if bus1 ();

   assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;
   assign bus0.in_pc    = in_pc;     assign bus1.in_pc    = in_pc;
   assign bus0.in_reg1  = in_reg1;   assign bus1.in_reg1  = in_reg1;
   assign bus0.in_reg2  = in_reg2;   assign bus1.in_reg2  = in_reg2;
   assign bus0.in_Imm   = in_Imm;    assign bus1.in_Imm   = in_Imm;
   assign bus0.in_rd    = in_rd;     assign bus1.in_rd    = in_rd;
   assign bus0.in_op    = in_op;     assign bus1.in_op    = in_op;
   assign bus0.mem_stall = mem_stall; assign bus1.mem_stall = 1'b0;

   ex_stage #(.SERIAL_SHIFT(1'b1)) u_dut   (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus0));
   ex_stage #(.SERIAL_SHIFT(1'b0)) u_dut_b (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // Monitor: first cycle of each result is compared against the queue head.
   always @(negedge clk) begin
      if (bus0.out_valid && !seen) begin
         seen = 1'b1;
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid: got op %0d wdata 0x%08h with nothing pending", bus0.out_op, bus0.out_wdata);
         end else begin
            mon_e = q.pop_front();
            chk("latency_cycle", cyc, mon_e.due);
            chk("out_op", bus0.out_op, mon_e.op);
            chk("out_rd", bus0.out_rd, mon_e.rd);
            chk("out_wen", bus0.out_wen, mon_e.wen);
            chk("br_taken", bus0.br_taken, mon_e.taken);
            if (mon_e.cwd) chk("out_wdata", bus0.out_wdata, mon_e.wdata);
            if (mon_e.taken) chk("br_target", bus0.br_target, mon_e.tgt);
            if (mon_e.cmem) begin
               chk("out_addr", bus0.out_addr, mon_e.addr);
               chk("out_sdata", bus0.out_sdata, mon_e.sdata);
            end
         end
      end else if (bus0.out_valid) begin
         chk("br_taken_repeat", bus0.br_taken, 1'b0);
      end
      if (!bus0.out_valid || (!bus0.mem_stall && rdy)) seen = 1'b0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t mk(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] wd,
                               input bit cwd, input bit wen, input bit tk, input logic [31:0] tgt);
      exp_t e;
      e.op = op; e.rd = rd; e.wdata = wd; e.cwd = cwd; e.wen = wen; e.taken = tk; e.tgt = tgt;
      e.cmem = 1'b0; e.addr = '0; e.sdata = '0; e.due = 0;
      return e;
   endfunction

   task automatic drive(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] imm, input logic [4:0] rd);
      in_valid = 1'b1; in_op = op; in_pc = pc; in_reg1 = r1; in_reg2 = r2; in_Imm = imm; in_rd = rd;
   endtask

   task automatic expect_res(input exp_t e, input int lat);
      e.due = cyc + lat;
      q.push_back(e);
   endtask

   task automatic issue(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] imm, input logic [4:0] rd,
                        input exp_t e, input int lat);
      drive(op, pc, r1, r2, imm, rd);
      expect_res(e, lat);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && q.size() > 0; i++) tick();
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: got %0d results still pending, want 0", q.size());
         q.delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_out_valid", bus0.out_valid, 1'b0);
      chk("rst_out_op", bus0.out_op, OP_NOP);
      chk("rst_out_wen", bus0.out_wen, 1'b0);
      chk("rst_out_wdata", bus0.out_wdata, 32'h0);
      chk("rst_br_taken", bus0.br_taken, 1'b0);
      chk("rst_ex_busy", bus0.ex_busy, 1'b0);
      tick();
      rst = 1'b0;
      tick();

      // Single-cycle ALU ops, back to back.
      issue(OP_ADDI, 0, 32'hFFFFFFFF, 0, 32'd2, 5'd5, mk(OP_ADDI, 5, 32'h1, 1, 1, 0, 0), 1);
      issue(OP_SUB, 0, 32'd3, 32'd5, 0, 5'd2, mk(OP_SUB, 2, 32'hFFFFFFFE, 1, 1, 0, 0), 1);
      issue(OP_SLT, 0, 32'hFFFFFFFF, 32'd1, 0, 5'd3, mk(OP_SLT, 3, 32'h1, 1, 1, 0, 0), 1);
      issue(OP_SLTIU, 0, 32'd5, 0, 32'hFFFFFFFF, 5'd8, mk(OP_SLTIU, 8, 32'h1, 1, 1, 0, 0), 1);
      issue(OP_LUI, 0, 0, 0, 32'h12345000, 5'd9, mk(OP_LUI, 9, 32'h12345000, 1, 1, 0, 0), 1);
      issue(OP_AUIPC, 32'h1000, 0, 0, 32'h2000, 5'd10, mk(OP_AUIPC, 10, 32'h3000, 1, 1, 0, 0), 1);
      issue(OP_XORI, 0, 32'h0F0F0F0F, 0, 32'hFFFFFFFF, 5'd11, mk(OP_XORI, 11, 32'hF0F0F0F0, 1, 1, 0, 0), 1);
      issue(OP_ADD, 0, 32'd1, 32'd2, 0, 5'd0, mk(OP_ADD, 0, 32'h3, 1, 0, 0, 0), 1);
      issue(OP_SRL, 0, 32'h80000000, 32'h21, 0, 5'd12, mk(OP_SRL, 12, 32'h40000000, 1, 1, 0, 0), 1);
      issue(OP_SRA, 0, 32'h80000000, 32'h20, 0, 5'd13, mk(OP_SRA, 13, 32'h80000000, 1, 1, 0, 0), 1);
      drain();

      // Serial SRAI by 4, with the barrel-shift instance alongside.
      drive(OP_SRAI, 0, 32'h80000000, 0, 32'd4, 5'd6);
      expect_res(mk(OP_SRAI, 6, 32'hF8000000, 1, 1, 0, 0), 4);
      @(negedge clk);
      chk("srai_busy_c0", bus0.ex_busy, 1'b1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("barrel_valid", bus1.out_valid, 1'b1);
      chk("barrel_wdata", bus1.out_wdata, 32'hF8000000);
      chk("srai_busy_c1", bus0.ex_busy, 1'b1);
      for (int i = 2; i < 4; i++) begin
         tick();
         @(negedge clk);
         chk("srai_busy_mid", bus0.ex_busy, 1'b1);
      end
      tick();
      @(negedge clk);
      chk("srai_busy_done", bus0.ex_busy, 1'b0);
      drain();

      // Branches and jumps.
      issue(OP_BEQ, 32'h100, 32'd7, 32'd7, 32'hFFFFFFF8, 5'd4, mk(OP_BEQ, 4, 0, 0, 0, 1, 32'h0F8), 1);
      tick();
      @(negedge clk);
      chk("br_one_cycle", bus0.br_taken, 1'b0);
      tick();
      issue(OP_BEQ, 32'h100, 32'd7, 32'd8, 32'hFFFFFFF8, 5'd4, mk(OP_BEQ, 4, 0, 0, 0, 0, 0), 1);
      issue(OP_BLTU, 32'h300, 32'd1, 32'hFFFFFFFF, 32'h10, 5'd0, mk(OP_BLTU, 0, 0, 0, 0, 1, 32'h310), 1);
      issue(OP_BGE, 32'h300, 32'hFFFFFFFF, 32'd1, 32'h10, 5'd0, mk(OP_BGE, 0, 0, 0, 0, 0, 0), 1);
      issue(OP_JALR, 32'h40, 32'h1003, 0, 0, 5'd1, mk(OP_JALR, 1, 32'h44, 1, 1, 1, 32'h1002), 1);

      // Memory ops.
      e = mk(OP_SW, 0, 0, 0, 0, 0, 0);
      e.cmem = 1'b1; e.addr = 32'h1008; e.sdata = 32'hDEADBEEF;
      issue(OP_SW, 0, 32'h1000, 32'hDEADBEEF, 32'd8, 5'd0, e, 1);
      e = mk(OP_LW, 10, 0, 0, 1, 0, 0);
      e.cmem = 1'b1; e.addr = 32'h1FFC; e.sdata = 32'h55;
      issue(OP_LW, 0, 32'h2000, 32'h55, 32'hFFFFFFFC, 5'd10, e, 1);
      drain();
      @(negedge clk);
      chk("idle_out_valid", bus0.out_valid, 1'b0);
      chk("idle_out_op", bus0.out_op, OP_NOP);
      chk("idle_out_wen", bus0.out_wen, 1'b0);
      tick();

      // MEM back-pressure on a taken jump, then accept on release.
      issue(OP_JAL, 32'h200, 0, 0, 32'h20, 5'd3, mk(OP_JAL, 3, 32'h204, 1, 1, 1, 32'h220), 1);
      mem_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_busy", bus0.ex_busy, 1'b1);
         chk("stall_wdata", bus0.out_wdata, 32'h204);
         tick();
      end
      mem_stall = 1'b0;
      drive(OP_ADD, 0, 32'd5, 32'd7, 0, 5'd2);
      expect_res(mk(OP_ADD, 2, 32'd12, 1, 1, 0, 0), 1);
      @(negedge clk);
      chk("hold_release_busy", bus0.ex_busy, 1'b1);
      tick();
      in_valid = 1'b0;
      drain();

      // Reset in the middle of a long serial shift.
      drive(OP_SLL, 0, 32'd1, 32'd20, 0, 5'd7);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("sll_busy", bus0.ex_busy, 1'b1);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", bus0.out_valid, 1'b0);
      chk("mid_rst_out_op", bus0.out_op, OP_NOP);
      chk("mid_rst_busy", bus0.ex_busy, 1'b0);
      repeat (25) tick();

      // rdy low for 3 cycles during a shift stretches latency by 3.
      drive(OP_SLLI, 0, 32'd3, 0, 32'd6, 5'd9);
      expect_res(mk(OP_SLLI, 9, 32'hC0, 1, 1, 0, 0), 9);
      tick();
      in_valid = 1'b0;
      tick();
      rdy = 1'b0;
      @(negedge clk);
      chk("rdy_low_busy", bus0.ex_busy, 1'b1);
      repeat (3) tick();
      rdy = 1'b1;
      drain();
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
